lsu_bus_ctrl: RTL and testbench

//  Load/store unit downstream of the control decoder. It consumes MemWrite, DMType, ALU address and rs2 data.

---
 rtl/lsu_bus_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_lsu_bus_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl
//   Load/store unit sitting behind the control decoder. Each memory
//   instruction becomes exactly one valid/ready bus transaction. The CPU is
//   stalled until the transaction completes. Misaligned accesses are flagged
//   and never reach the bus. Transactions that stall too long are aborted
//   with bus_err.
//
// Parameters
//   TO_W     width of the REQ/WAIT timeout counter
//   TIMEOUT  cycles allowed in REQ+WAIT before abort (0 disables the timeout)
//
// Ports
//   clk, rstn            rising-edge clock, asynchronous active-low reset
//   req_valid            memory instruction present (held while stall=1)
//   req_we               1 = store, 0 = load
//   req_dmtype           000 w, 001 h, 010 hu, 011 b, 100 bu (101-111 -> w)
//   req_addr, req_wdata  byte address and store data (rs2)
//   stall                hold PC/regfile this cycle
//   rdata                extended load result
//   done                 one-cycle completion pulse (errors included)
//   misalign, bus_err    completion status, meaningful only with done
//   bus_req_valid/ready  request handshake
//   bus_we, bus_addr     request type and word-aligned address
//   bus_be, bus_wdata    byte enables and lane-replicated store data
//   bus_rsp_valid        read data strobe (only honoured in WAIT)
//   bus_rdata            read data word
module lsu_bus_ctrl #(
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_dmtype,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t state_q, state_d;

  // Request captured in IDLE; the inputs are not looked at again until the
  // next IDLE, so a req_valid drop mid-transaction cannot abort it.
  logic [31:0]     addr_q;
  logic            we_q;
  logic [2:0]      dmtype_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic            mis_q;
  logic            err_q;
  logic [TO_W-1:0] cnt_q;
  logic [31:0]     rdata_q;

  // Decode of the incoming request.
  logic        in_half;
  logic        in_byte;
  logic        in_misalign;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;

  always_comb begin
    in_half     = (req_dmtype == 3'b001) || (req_dmtype == 3'b010);
    in_byte     = (req_dmtype == 3'b011) || (req_dmtype == 3'b100);
    in_be       = 4'b1111;
    in_wdata    = req_wdata;
    in_misalign = 1'b0;
    if (in_byte) begin
      in_be    = 4'b0001 << req_addr[1:0];
      in_wdata = {4{req_wdata[7:0]}};
    end else if (in_half) begin
      in_be       = req_addr[1] ? 4'b1100 : 4'b0011;
      in_wdata    = {2{req_wdata[15:0]}};
      in_misalign = req_addr[0];
    end else begin
      in_misalign = |req_addr[1:0];
    end
  end

  // Little-endian lane extraction plus sign/zero extension.
  function automatic logic [31:0] load_extend(input logic [2:0]  dt,
                                              input logic [1:0]  o,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {o, 3'b000});
    h = 16'(w >> {o[1], 4'b0000});
    case (dt)
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return {16'h0000, h};
      3'b011:  return {{24{b[7]}}, b};
      3'b100:  return {24'h000000, b};
      default: return w;
    endcase
  endfunction

  logic timeout_hit;
  logic rsp_take;
  logic abort;

  always_comb begin
    timeout_hit = TO_EN && (cnt_q == TO_LAST);
    rsp_take    = (state_q == S_WAIT) && bus_rsp_valid;
    // A handshake or response arriving on the last allowed cycle still wins.
    abort       = timeout_hit &&
                  (((state_q == S_REQ)  && !bus_req_ready) ||
                   ((state_q == S_WAIT) && !bus_rsp_valid));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    stall         = req_valid && (state_q != S_DONE);
    done          = 1'b0;
    misalign      = 1'b0;
    bus_err       = 1'b0;
    bus_req_valid = 1'b0;
    bus_we        = 1'b0;
    bus_addr      = '0;
    bus_be        = '0;
    bus_wdata     = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = in_misalign ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        bus_req_valid = 1'b1;
        bus_we        = we_q;
        bus_addr      = {addr_q[31:2], 2'b00};
        bus_be        = be_q;
        bus_wdata     = wdata_q;
        if (bus_req_ready) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (abort) begin
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (rsp_take || abort) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        misalign = mis_q;
        bus_err  = err_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      dmtype_q <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            we_q     <= req_we;
            dmtype_q <= req_dmtype;
            be_q     <= in_be;
            wdata_q  <= in_wdata;
            mis_q    <= in_misalign;
            err_q    <= 1'b0;
            cnt_q    <= '0;
          end
        end
        S_REQ, S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (rsp_take) begin
            rdata_q <= load_extend(dmtype_q, addr_q[1:0], bus_rdata);
          end else if (abort) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: table of single transactions plus hand-written
// sequences for timeout, reset during WAIT and back-to-back operations.
// Expected completions are queued when an operation is issued and checked
// when the DUT signals done; bus requests are checked against the queue head.
module tb_lsu_bus_ctrl;

  localparam int unsigned TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_dmtype;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        done;
  logic        misalign;
  logic        bus_err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  lsu_bus_ctrl #(.TO_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_dmtype    (req_dmtype),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .stall         (stall),
    .rdata         (rdata),
    .done          (done),
    .misalign      (misalign),
    .bus_err       (bus_err),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_be        (bus_be),
    .bus_wdata     (bus_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rdata     (bus_rdata)
  );

  typedef struct {
    logic        we;
    logic [2:0]  dt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic [31:0] rdata;
    logic        mis;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic [31:0] rdata;
    logic        mis;
    logic        err;
    int unsigned stall;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[17];
  int          checks = 0;
  int          errors = 0;
  int unsigned stall_cnt;
  int unsigned req_cnt;
  logic        pend;
  logic        rsp_block;
  logic        force_rsp;
  logic        seen_done;
  logic        seen_hs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs at the falling edge: bus responder plus scoreboard checks.
  task automatic monitor();
    exp_t e;
    seen_done = 1'b0;
    seen_hs   = 1'b0;
    if (!rstn) begin
      stall_cnt     = 0;
      req_cnt       = 0;
      pend          = 1'b0;
      bus_rsp_valid = force_rsp;
      return;
    end
    bus_rsp_valid = (pend && !rsp_block) || force_rsp;
    pend          = bus_req_valid && bus_req_ready && !bus_we;
    if (stall) stall_cnt++;
    if (bus_req_valid) req_cnt++;
    if (bus_req_valid && bus_req_ready) begin
      seen_hs = 1'b1;
      if (sb.size() == 0) begin
        chk("req_outstanding", 32'd0, 32'd1);
      end else begin
        e = sb[0];
        chk("bus_addr", bus_addr, {e.addr[31:2], 2'b00});
        chk("bus_be", {28'h0, bus_be}, {28'h0, e.be});
        chk("bus_we", {31'h0, bus_we}, {31'h0, e.we});
        if (e.we) chk("bus_wdata", bus_wdata, e.bwdata);
      end
    end
    if (done) begin
      seen_done = 1'b1;
      if (sb.size() == 0) begin
        chk("done_outstanding", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("misalign", {31'h0, misalign}, {31'h0, e.mis});
        chk("bus_err", {31'h0, bus_err}, {31'h0, e.err});
        chk("rdata", rdata, e.rdata);
        chk("stall_cycles", stall_cnt, e.stall);
        if (e.mis) chk("no_bus_on_misalign", req_cnt, 32'd0);
      end
      stall_cnt = 0;
      req_cnt   = 0;
    end else begin
      chk("misalign_without_done", {31'h0, misalign}, 32'd0);
      chk("bus_err_without_done", {31'h0, bus_err}, 32'd0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic we, input logic [2:0] dt, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rword,
                        input exp_t e, input int unsigned budget);
    req_we     = we;
    req_dmtype = dt;
    req_addr   = addr;
    req_wdata  = wdata;
    bus_rdata  = rword;
    req_valid  = 1'b1;
    sb.push_back(e);
    for (int unsigned n = 0; n < budget; n++) begin
      tick();
      if (seen_done) break;
    end
    chk("op_done_within_budget", {31'h0, seen_done}, 32'd1);
    req_valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    vec_t v;

    vecs[0]  = '{1'b1, 3'b011, 32'h103, 32'h000000A5, 32'h0,        4'b1000, 32'hA5A5A5A5, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 3'b011, 32'h102, 32'h0,        32'h00800000, 4'b0100, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b0, 3'b100, 32'h102, 32'h0,        32'h00800000, 4'b0100, 32'h0,        32'h00000080, 1'b0};
    vecs[3]  = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h00800000, 4'b1100, 32'h0,        32'h00000080, 1'b0};
    vecs[4]  = '{1'b0, 3'b001, 32'h100, 32'h0,        32'h12348001, 4'b0011, 32'h0,        32'hFFFF8001, 1'b0};
    vecs[5]  = '{1'b0, 3'b000, 32'h204, 32'h0,        32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[6]  = '{1'b1, 3'b001, 32'h302, 32'h1234ABCD, 32'h0,        4'b1100, 32'hABCDABCD, 32'hDEADBEEF, 1'b0};
    vecs[7]  = '{1'b1, 3'b000, 32'h400, 32'hCAFEF00D, 32'h0,        4'b1111, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0};
    vecs[8]  = '{1'b0, 3'b000, 32'h002, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hDEADBEEF, 1'b1};
    vecs[9]  = '{1'b0, 3'b001, 32'h101, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hDEADBEEF, 1'b1};
    vecs[10] = '{1'b1, 3'b010, 32'h303, 32'h00000001, 32'h0,        4'b0000, 32'h0,        32'hDEADBEEF, 1'b1};
    vecs[11] = '{1'b0, 3'b011, 32'h101, 32'h0,        32'h00007F00, 4'b0010, 32'h0,        32'h0000007F, 1'b0};
    vecs[12] = '{1'b0, 3'b111, 32'h010, 32'h0,        32'h80000001, 4'b1111, 32'h0,        32'h80000001, 1'b0};
    vecs[13] = '{1'b0, 3'b110, 32'h011, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h80000001, 1'b1};
    vecs[14] = '{1'b1, 3'b011, 32'h000, 32'hFFFFFF3C, 32'h0,        4'b0001, 32'h3C3C3C3C, 32'h80000001, 1'b0};
    vecs[15] = '{1'b0, 3'b001, 32'h102, 32'h0,        32'hFFFE1234, 4'b1100, 32'h0,        32'hFFFFFFFE, 1'b0};
    vecs[16] = '{1'b0, 3'b100, 32'h103, 32'h0,        32'hF1000000, 4'b1000, 32'h0,        32'h000000F1, 1'b0};

    rstn          = 1'b0;
    req_valid     = 1'b0;
    req_we        = 1'b0;
    req_dmtype    = 3'b000;
    req_addr      = 32'h0;
    req_wdata     = 32'h0;
    bus_req_ready = 1'b1;
    bus_rsp_valid = 1'b0;
    bus_rdata     = 32'h0;
    pend          = 1'b0;
    rsp_block     = 1'b0;
    force_rsp     = 1'b0;
    seen_done     = 1'b0;
    seen_hs       = 1'b0;
    stall_cnt     = 0;
    req_cnt       = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_stall", {31'h0, stall}, 32'd0);
    chk("rst_bus_req_valid", {31'h0, bus_req_valid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_misalign", {31'h0, misalign}, 32'd0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'd0);
    chk("rst_bus_be", {28'h0, bus_be}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    rstn = 1'b1;
    tick();

    // Table of single operations on a zero-wait bus.
    foreach (vecs[i]) begin
      v        = vecs[i];
      e.we     = v.we;
      e.addr   = v.addr;
      e.be     = v.be;
      e.bwdata = v.bwdata;
      e.rdata  = v.rdata;
      e.mis    = v.mis;
      e.err    = 1'b0;
      e.stall  = v.mis ? 1 : (v.we ? 2 : 3);
      run_op(v.we, v.dt, v.addr, v.wdata, v.rword, e, 20);
      tick();
    end

    // Timeout: ready never arrives.
    bus_req_ready = 1'b0;
    e = '{1'b0, 32'h500, 4'b1111, 32'h0, 32'h0, 1'b0, 1'b1, 1 + TIMEOUT};
    run_op(1'b0, 3'b000, 32'h500, 32'h0, 32'h12345678, e, 3 * TIMEOUT);
    bus_req_ready = 1'b1;
    tick();
    e = '{1'b0, 32'h504, 4'b1111, 32'h0, 32'h11223344, 1'b0, 1'b0, 3};
    run_op(1'b0, 3'b000, 32'h504, 32'h0, 32'h11223344, e, 20);
    tick();

    // Reset asserted while the load waits for its response.
    rsp_block  = 1'b1;
    req_we     = 1'b0;
    req_dmtype = 3'b000;
    req_addr   = 32'h700;
    bus_rdata  = 32'h99999999;
    req_valid  = 1'b1;
    sb.push_back('{1'b0, 32'h700, 4'b1111, 32'h0, 32'h0, 1'b0, 1'b0, 0});
    for (int unsigned n = 0; n < 20; n++) begin
      tick();
      if (seen_hs) break;
    end
    chk("wait_reached", {31'h0, seen_hs}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("rstwait_bus_req_valid", {31'h0, bus_req_valid}, 32'd0);
    chk("rstwait_done", {31'h0, done}, 32'd0);
    chk("rstwait_rdata", rdata, 32'd0);
    chk("rstwait_bus_err", {31'h0, bus_err}, 32'd0);
    req_valid = 1'b0;
    sb.delete();
    #1;
    chk("rstwait_stall", {31'h0, stall}, 32'd0);
    force_rsp = 1'b1;
    tick();
    rstn      = 1'b1;
    rsp_block = 1'b0;
    repeat (3) tick();
    chk("stale_rsp_rdata", rdata, 32'd0);
    chk("stale_rsp_bus_idle", {31'h0, bus_req_valid}, 32'd0);
    force_rsp = 1'b0;
    tick();
    e = '{1'b1, 32'h001, 4'b0010, 32'h7E7E7E7E, 32'h0, 1'b0, 1'b0, 2};
    run_op(1'b1, 3'b011, 32'h001, 32'h0000007E, 32'h0, e, 20);

    // Back-to-back load then store with req_valid held across the boundary.
    e = '{1'b0, 32'h600, 4'b1111, 32'h0, 32'hA0B0C0D0, 1'b0, 1'b0, 3};
    run_op(1'b0, 3'b000, 32'h600, 32'h0, 32'hA0B0C0D0, e, 20);
    e = '{1'b1, 32'h604, 4'b1111, 32'h00000055, 32'hA0B0C0D0, 1'b0, 1'b0, 2};
    run_op(1'b1, 3'b000, 32'h604, 32'h00000055, 32'h0, e, 20);
    repeat (2) tick();
    chk("queue_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
